// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point operation sequencer and its
// execution units.
package fp_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_INVALID   = 3'd1,
    ERR_DIV0      = 3'd2,
    ERR_OVERFLOW  = 3'd3,
    ERR_UNDERFLOW = 3'd4,
    ERR_INEXACT   = 3'd5
  } o_err_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_t;

  localparam int unsigned N_UNITS     = 3;
  localparam logic [1:0]  UNIT_ADDSUB = 2'd0;
  localparam logic [1:0]  UNIT_MUL    = 2'd1;
  localparam logic [1:0]  UNIT_DIV    = 2'd2;
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;

  // ADD and SUB share unit 0; ex_sub tells that unit which one to perform.
  function automatic logic [1:0] unit_of(opcode_t opc);
    case (opc)
      OP_MUL:  return UNIT_MUL;
      OP_DIV:  return UNIT_DIV;
      default: return UNIT_ADDSUB;
    endcase
  endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// Request queue: DEPTH-entry FIFO with wrap-bit pointers. The head entry is
// visible combinationally so the consumer can register it on the pop edge.
module fp_req_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]      wr_ptr_reg;
  logic [IDX_W:0]      rd_ptr_reg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                do_push;
  logic                do_pop;

  assign full    = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                   (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  // A pop in the same cycle never frees a slot for a push into a full queue.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fp_op_sequencer.sv
// Queues FP requests and runs them one at a time on the add/sub, mul or div
// unit, returning the result (or a qNaN on unit timeout) strictly in order.
module fp_op_sequencer
  import fp_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  opcode_t          req_opc,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       ex_start,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic             ex_sub,
  input  logic [2:0]       ex_done,
  input  logic [31:0]      ex_result [N_UNITS],
  input  o_err_t           ex_err [N_UNITS],
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output o_err_t           rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy,
  output logic [15:0]      ops_done
);

  localparam int ENTRY_W = 2 + 32 + 32 + TAG_W;
  localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  seq_state_t         state_reg;
  logic [1:0]         unit_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [CNT_W-1:0]   wait_cnt_reg;

  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  opcode_t            head_opc;
  logic [31:0]        head_a;
  logic [31:0]        head_b;
  logic [TAG_W-1:0]   head_tag;
  logic               done_sel;

  assign fifo_wr_data = {req_opc, req_a, req_b, req_tag};
  assign head_opc     = opcode_t'(fifo_rd_data[ENTRY_W-1 -: 2]);
  assign head_a       = fifo_rd_data[TAG_W+63 -: 32];
  assign head_b       = fifo_rd_data[TAG_W+31 -: 32];
  assign head_tag     = fifo_rd_data[TAG_W-1:0];

  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
  assign req_ready = !fifo_full;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;
  // Only the unit that was started may end the wait; other done bits are noise.
  assign done_sel  = ex_done[unit_reg];

  fp_req_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_valid),
    .pop     (fifo_pop),
    .wr_data (fifo_wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      unit_reg     <= UNIT_ADDSUB;
      tag_reg      <= '0;
      wait_cnt_reg <= '0;
      ex_start     <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_sub       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_err      <= ERR_NONE;
      rsp_tag      <= '0;
      rsp_timeout  <= 1'b0;
      ops_done     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            unit_reg  <= unit_of(head_opc);
            tag_reg   <= head_tag;
            ex_start  <= 3'b001 << unit_of(head_opc);
            ex_a      <= head_a;
            ex_b      <= head_b;
            ex_sub    <= (head_opc == OP_SUB);
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ex_start     <= '0;
          wait_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_sel) begin
            rsp_result  <= ex_result[unit_reg];
            rsp_err     <= ex_err[unit_reg];
            rsp_timeout <= 1'b0;
            rsp_tag     <= tag_reg;
            rsp_valid   <= 1'b1;
            state_reg   <= ST_RESP;
          end else if (wait_cnt_reg == CNT_LAST) begin
            // rsp_err deliberately keeps the previous operation's code.
            rsp_result  <= QNAN;
            rsp_timeout <= 1'b1;
            rsp_tag     <= tag_reg;
            rsp_valid   <= 1'b1;
            state_reg   <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed and randomized bench for fp_op_sequencer with a behavioural model of
// the three execution units and an in-order response scoreboard.
module tb_fp_op_sequencer;
  import fp_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  opcode_t          req_opc = OP_ADD;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [2:0]       ex_start;
  logic [31:0]      ex_a;
  logic [31:0]      ex_b;
  logic             ex_sub;
  logic [2:0]       ex_done;
  logic [31:0]      ex_result [3];
  o_err_t           ex_err [3];
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  o_err_t           rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic             busy;
  logic [15:0]      ops_done;

  always #5 clk = ~clk;

  fp_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .ex_start(ex_start), .ex_a(ex_a), .ex_b(ex_b), .ex_sub(ex_sub),
    .ex_done(ex_done), .ex_result(ex_result), .ex_err(ex_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .busy(busy), .ops_done(ops_done)
  );

  typedef struct {
    opcode_t          opc;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic             hang;
  } req_t;

  typedef struct {
    logic [31:0]      result;
    o_err_t           err;
    logic [TAG_W-1:0] tag;
    logic             timeout;
  } rsp_t;

  req_t        issue_q[$];
  rsp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fixed_lat = -1;
  bit          noise_all = 1'b0;
  int          late_pulse = 0;
  logic [15:0] ops_model = '0;
  o_err_t      last_err_model = ERR_NONE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Unit behaviour: integer stand-ins for FP maths plus one known-answer entry.
  function automatic logic [31:0] unit_result(opcode_t opc, logic [31:0] a, logic [31:0] b);
    case (opc)
      OP_ADD:  return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return (b == 0) ? 32'h0 : a / b;
    endcase
  endfunction

  function automatic o_err_t unit_err(opcode_t opc, logic [31:0] a, logic [31:0] b);
    if (opc == OP_DIV && b == 0) return ERR_DIV0;
    if (a[0] && b[0])            return ERR_INEXACT;
    if (opc == OP_MUL && (a[31] ^ b[31])) return ERR_OVERFLOW;
    return ERR_NONE;
  endfunction

  function automatic logic is_hang(opcode_t opc, logic [31:0] a);
    return (opc == OP_DIV) && (a == 32'hFFFF_FFFF);
  endfunction

  task automatic push(input opcode_t opc, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    req_t r;
    rsp_t e;
    int n;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("push_ready", 32'(req_ready), 32'd1);
    if (!req_ready) return;
    req_valid = 1'b1; req_opc = opc; req_a = a; req_b = b; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
    r.opc = opc; r.a = a; r.b = b; r.tag = tag; r.hang = is_hang(opc, a);
    issue_q.push_back(r);
    e.tag = tag;
    if (r.hang) begin
      e.result = QNAN; e.err = last_err_model; e.timeout = 1'b1;
    end else begin
      e.result = unit_result(opc, a, b); e.err = unit_err(opc, a, b); e.timeout = 1'b0;
      last_err_model = e.err;
    end
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic take_rsp(input int hold, output int n);
    rsp_t e;
    wait_valid(n);
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    if (!rsp_valid) return;
    chk("rsp_expected", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
      chk("rsp_result", rsp_result, e.result);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
      chk("ops_done_hold", 32'(ops_done), 32'(ops_model));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ops_model++;
    chk("ops_done_inc", 32'(ops_done), 32'(ops_model));
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic drive_noise(input int u);
    for (int i = 0; i < 3; i++) begin
      ex_result[i] = $urandom;
      ex_err[i]    = o_err_t'(3'($urandom_range(0, 5)));
      if (i != u) ex_done[i] = noise_all ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic serve_issue();
    req_t r;
    int u;
    int lat;
    opcode_t eff;
    chk("issue_expected", 32'(issue_q.size() > 0), 32'd1);
    if (issue_q.size() == 0) return;
    r = issue_q.pop_front();
    u = int'(unit_of(r.opc));
    chk("ex_start_onehot", 32'(ex_start), 32'(3'b001 << u));
    chk("ex_a_issue", ex_a, r.a);
    chk("ex_b_issue", ex_b, r.b);
    chk("ex_sub_issue", 32'(ex_sub), 32'(r.opc == OP_SUB));
    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      ex_done = '0;
      if (!reset_n) return;
      if (r.hang && rsp_valid) return;
      if (cyc == 0) chk("ex_start_pulse", 32'(ex_start), 32'd0);
      chk("ex_a_stable", ex_a, r.a);
      chk("ex_b_stable", ex_b, r.b);
      chk("ex_sub_stable", 32'(ex_sub), 32'(r.opc == OP_SUB));
      drive_noise(u);
      if (!r.hang && cyc == lat) begin
        eff = (u == 0) ? (ex_sub ? OP_SUB : OP_ADD) : ((u == 1) ? OP_MUL : OP_DIV);
        if (noise_all) ex_done = '0;
        ex_done[u]   = 1'b1;
        ex_result[u] = unit_result(eff, ex_a, ex_b);
        ex_err[u]    = unit_err(eff, ex_a, ex_b);
        return;
      end
    end
  endtask

  initial begin : unit_model
    ex_done = '0;
    for (int i = 0; i < 3; i++) begin ex_result[i] = '0; ex_err[i] = ERR_NONE; end
    forever begin
      @(negedge clk);
      ex_done = '0;
      if (late_pulse > 0) begin
        ex_done = 3'b111;
        late_pulse--;
      end else if (reset_n && ex_start != 3'b000) begin
        serve_issue();
      end
    end
  end

  task automatic check_idle_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_ex_start", 32'(ex_start), 32'd0);
    chk("rst_ex_a", ex_a, 32'd0);
    chk("rst_ex_b", ex_b, 32'd0);
    chk("rst_ex_sub", 32'(ex_sub), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int k;
    opcode_t o;
    logic [31:0] a;
    logic [31:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // Known-answer ADD, minimum latency, one-cycle start pulse
    fixed_lat = 0;
    push(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd1);
    take_rsp(0, n);
    chk("min_latency", 32'(n), 32'd3);

    // Park one response, fill the queue behind it, hold rsp_ready low
    push(OP_ADD, 32'h0000_0010, 32'h0000_0003, 4'd5);
    wait_valid(n);
    chk("park_valid", 32'(rsp_valid), 32'd1);
    push(OP_MUL, 32'h0000_0007, 32'h0000_0006, 4'd6);
    push(OP_DIV, 32'h0000_0064, 32'h0000_0005, 4'd7);
    push(OP_SUB, 32'h0000_0100, 32'h0000_0001, 4'd8);
    push(OP_ADD, 32'h0000_0002, 32'h0000_0002, 4'd9);
    chk("full_after_4", 32'(req_ready), 32'd0);
    chk("busy_full", 32'(busy), 32'd1);
    take_rsp(6, n);
    for (int i = 0; i < 4; i++) take_rsp(0, n);

    // DIV that never completes, followed by a normal ADD
    push(OP_DIV, 32'hFFFF_FFFF, 32'h0000_0001, 4'd10);
    push(OP_ADD, 32'h0000_0011, 32'h0000_0022, 4'd11);
    take_rsp(0, n);
    chk("timeout_latency", 32'(n), 32'(1 + TMO));
    take_rsp(0, n);

    // Unselected done bits asserted throughout a MUL wait
    noise_all = 1'b1;
    fixed_lat = 3;
    push(OP_MUL, 32'h0000_0009, 32'h0000_0005, 4'd12);
    take_rsp(0, n);
    chk("noise_latency", 32'(n), 32'd6);
    noise_all = 1'b0;

    // Reset during WAIT with two requests queued
    fixed_lat = 10;
    push(OP_MUL, 32'h0000_0003, 32'h0000_0003, 4'd13);
    push(OP_ADD, 32'h0000_0001, 32'h0000_0001, 4'd14);
    push(OP_SUB, 32'h0000_0005, 32'h0000_0001, 4'd15);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_outputs();
    issue_q.delete();
    sb_q.delete();
    ops_model = '0;
    last_err_model = ERR_NONE;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    late_pulse = 3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_no_start", 32'(ex_start), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    fixed_lat = -1;

    // Randomized batches against the scoreboard
    for (int bt = 0; bt < 30; bt++) begin
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        o = opcode_t'(2'($urandom_range(0, 3)));
        a = $urandom;
        b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
        if (o == OP_DIV && $urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
        push(o, a, b, TAG_W'($urandom));
        if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      for (int j = 0; j < k; j++) take_rsp(int'($urandom_range(0, 3)), n);
      chk("batch_drained_busy", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
